// File: rtl/zelda_pkg.sv
// Shared game datapath definitions: screen geometry, field widths, pixel
// record and the xy -> linear framebuffer address mapping.
package zelda_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 6;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int ADDR_W   = 17;

  // One buffered framebuffer write: linear address plus colour.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*320 + x as two shifts and adds (256y + 64y + x); max 76799 fits in 17b.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO with a combinational view of the head entry.
// A push into a full FIFO is only accepted when a pop happens the same cycle.
module pixel_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed, contents are gated by count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_writer.sv
// Framebuffer write stage: bounds-check and address each incoming pixel,
// buffer it through a small FIFO across framebuffer stalls, and count drops.
module vga_pixel_writer #(
  parameter int SCREEN_W   = zelda_pkg::SCREEN_W,
  parameter int SCREEN_H   = zelda_pkg::SCREEN_H,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [8:0]       in_x,
  input  logic [7:0]       in_y,
  input  logic [5:0]       in_colour,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [16:0]      fb_address,
  output logic [5:0]       fb_colour,
  output logic             fb_write,
  input  logic             fb_ready,
  output logic [CNT_W-1:0] oob_count,
  output logic [CNT_W-1:0] ovf_count,
  output logic             busy
);

  import zelda_pkg::*;

  logic   in_range;
  logic   s1_valid;
  pixel_t s1_pix;
  pixel_t head;
  logic   full, empty;

  assign in_range = (in_x < X_W'(SCREEN_W)) && (in_y < Y_W'(SCREEN_H));

  // Stage 1: register in-range pixels with their linear address.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
    end else begin
      s1_valid <= in_valid && in_range;
      if (in_valid && in_range) begin
        s1_pix.addr   <= xy_to_addr(in_x, in_y);
        s1_pix.colour <= in_colour;
      end
    end
  end

  // Saturating debug counters: out-of-range pixels and FIFO-full drops.
  // Full implies non-empty, so a full push is dropped exactly when fb_ready=0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      oob_count <= '0;
      ovf_count <= '0;
    end else begin
      if (in_valid && !in_range && oob_count != '1)
        oob_count <= oob_count + CNT_W'(1);
      if (s1_valid && full && !fb_ready && ovf_count != '1)
        ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  pixel_fifo #(
    .WIDTH($bits(pixel_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (s1_valid),
    .wdata (s1_pix),
    .pop   (fb_ready),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign fb_write   = !empty && fb_ready;
  assign fb_address = head.addr;
  assign fb_colour  = head.colour;
  assign in_ready   = !full;
  assign busy       = s1_valid || !empty;

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Directed bench for vga_pixel_writer: inputs change 1ns after a rising edge,
// outputs are checked there too, with expectations computed by hand/integer math.
module tb_vga_pixel_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [5:0]  in_colour;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] fb_address;
  logic [5:0]  fb_colour;
  logic        fb_write;
  logic        fb_ready;
  logic [7:0]  oob_count;
  logic [7:0]  ovf_count;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  vga_pixel_writer #(
    .SCREEN_W(320), .SCREEN_H(240), .FIFO_DEPTH(4), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_valid(in_valid),
    .in_ready(in_ready),
    .fb_address(fb_address), .fb_colour(fb_colour), .fb_write(fb_write),
    .fb_ready(fb_ready),
    .oob_count(oob_count), .ovf_count(ovf_count), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input int c, input logic v);
    in_x      = 9'(x);
    in_y      = 8'(y);
    in_colour = 6'(c);
    in_valid  = v;
  endtask

  function automatic int lin(input int x, input int y);
    return y * 320 + x;
  endfunction

  initial begin
    // 1. Reset held with a valid in-range pixel present.
    reset = 1'b0; fb_ready = 1'b1;
    drive(5, 5, 1, 1'b1);
    tick(); tick();
    check("rst_fb_write", fb_write, 0);
    check("rst_oob", oob_count, 0);
    check("rst_ovf", ovf_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_addr", fb_address, 0);
    check("rst_colour", fb_colour, 0);
    reset = 1'b1;
    drive(0, 0, 0, 1'b0);
    tick();
    check("post_rst_write", fb_write, 0);

    // 2. Single pixel at the far corner: written two edges later, one cycle.
    drive(319, 239, 6'h2A, 1'b1);
    tick();
    drive(0, 0, 0, 1'b0);
    check("single_n1_write", fb_write, 0);
    check("single_n1_busy", busy, 1);
    tick();
    check("single_write", fb_write, 1);
    check("single_addr", fb_address, 76799);
    check("single_colour", fb_colour, 6'h2A);
    tick();
    check("single_one_cycle", fb_write, 0);
    check("single_addr_idle", fb_address, 0);
    check("single_busy_idle", busy, 0);

    // 3. Bounds: x==320 and y==240 are both rejected; origin is written.
    drive(320, 0, 3, 1'b1);
    tick();
    check("oob1_write", fb_write, 0);
    drive(0, 240, 3, 1'b1);
    tick();
    check("oob2_write", fb_write, 0);
    drive(0, 0, 0, 1'b0);
    tick();
    check("oob_write", fb_write, 0);
    check("oob_count2", oob_count, 2);
    check("oob_busy", busy, 0);
    drive(0, 0, 6'h15, 1'b1);
    tick();
    drive(0, 0, 0, 1'b0);
    tick();
    check("origin_write", fb_write, 1);
    check("origin_addr", fb_address, 0);
    check("origin_colour", fb_colour, 6'h15);
    tick();
    check("origin_done", fb_write, 0);

    // 4. Stall: six pixels into a four-entry FIFO with fb_ready low.
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i + 10, i + 1, i + 1, 1'b1);
      tick();
      // after edge i+1: pixels 0..i-1 pushed (capped at 4)
      check("stall_in_ready", in_ready, (i < 4) ? 1 : 0);
    end
    drive(0, 0, 0, 1'b0);
    tick();
    check("stall_ovf", ovf_count, 2);
    check("stall_no_write", fb_write, 0);
    check("stall_head", fb_address, lin(10, 1));
    check("stall_in_ready_low", in_ready, 0);
    fb_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_write", fb_write, 1);
      check("drain_addr", fb_address, lin(i + 10, i + 1));
      check("drain_colour", fb_colour, i + 1);
      tick();
    end
    check("drain_done", fb_write, 0);
    check("drain_busy", busy, 0);
    check("drain_ovf_hold", ovf_count, 2);

    // 5. Full FIFO with simultaneous push and pop on a continuous stream.
    reset = 1'b0; tick(); reset = 1'b1;
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2 * i + 1, 100 + i, i, 1'b1);
      tick();
    end
    check("stream_full", in_ready, 0);
    fb_ready = 1'b1;
    for (int m = 0; m < 8; m++) begin
      drive(2 * (m + 5) + 1, 100 + m + 5, m + 5, 1'b1);
      #1;
      check("stream_write", fb_write, 1);
      check("stream_addr", fb_address, lin(2 * m + 1, 100 + m));
      tick();
    end
    drive(0, 0, 0, 1'b0);
    for (int m = 8; m < 13; m++) begin
      check("stream_tail_addr", fb_address, lin(2 * m + 1, 100 + m));
      check("stream_tail_write", fb_write, 1);
      tick();
    end
    check("stream_done", fb_write, 0);
    check("stream_ovf", ovf_count, 0);

    // 6. Reset mid-operation discards buffered pixels.
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(50 + i, 60, 7, 1'b1);
      tick();
    end
    drive(0, 0, 0, 1'b0);
    tick();
    check("mid_busy", busy, 1);
    check("mid_head", fb_address, lin(50, 60));
    reset = 1'b0; tick(); reset = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    fb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("mid_never_written", fb_write, 0);
      tick();
    end

    // Saturation of the out-of-range counter.
    for (int i = 0; i < 300; i++) begin
      drive(400, 10, 1, 1'b1);
      tick();
      if (i == 254) check("oob_at_255", oob_count, 255);
    end
    drive(0, 0, 0, 1'b0);
    tick();
    check("oob_saturated", oob_count, 255);
    check("oob_sat_no_write", fb_write, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
